// File: rtl/imem_pkg.sv
// Shared layout definitions for the byte-wide instruction memory.
// Loader and fetch side both import this so byte order stays consistent.
package imem_pkg;

   localparam int MEM_DEPTH   = 1024;
   localparam int ADDR_W      = 10;
   localparam int BYTE_STRIDE = 3;
   localparam int INSTR_W     = 24;
   localparam int IADDR_W     = 24;
   localparam int CNT_W       = 16;

   typedef enum logic [1:0] {
      IDLE,
      WR_B2,
      WR_B1,
      WR_B0
   } state_t;

   localparam int B2_LSB = 16;
   localparam int B1_LSB = 8;
   localparam int B0_LSB = 0;

endpackage

// File: rtl/imem_loader.sv
// Serialises 24-bit instruction words into three byte writes,
// MSB first, spaced BYTE_STRIDE apart in instruction memory.
module imem_loader
   import imem_pkg::*;
#(
   parameter int MEM_DEPTH   = imem_pkg::MEM_DEPTH,
   parameter int ADDR_W      = imem_pkg::ADDR_W,
   parameter int BYTE_STRIDE = imem_pkg::BYTE_STRIDE,
   parameter int CNT_W       = imem_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IADDR_W-1:0] in_addr,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [7:0]         mem_wdata,
   output logic               busy,
   output logic [CNT_W-1:0]   word_count,
   output logic               range_err
);

   state_t state, nxt;

   logic [ADDR_W-1:0]  a_q;
   logic [INSTR_W-1:0] i_q;
   logic [IADDR_W:0]   last_a;
   logic               legal;
   logic               accept;

   // Extra bit keeps the top-of-range sum from wrapping.
   assign last_a = {1'b0, in_addr} + (IADDR_W+1)'(2 * BYTE_STRIDE);
   assign legal  = last_a <= (IADDR_W+1)'(MEM_DEPTH - 1);

   assign in_ready = (state == IDLE) || (state == WR_B0);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (accept && legal) nxt = WR_B2;
         WR_B2: nxt = WR_B1;
         WR_B1: nxt = WR_B0;
         WR_B0: nxt = (accept && legal) ? WR_B2 : IDLE;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state)
         IDLE: ;
         WR_B2: begin
            mem_we    = 1'b1;
            mem_addr  = a_q;
            mem_wdata = i_q[B2_LSB +: 8];
         end
         WR_B1: begin
            mem_we    = 1'b1;
            mem_addr  = a_q + ADDR_W'(BYTE_STRIDE);
            mem_wdata = i_q[B1_LSB +: 8];
         end
         WR_B0: begin
            mem_we    = 1'b1;
            mem_addr  = a_q + ADDR_W'(2 * BYTE_STRIDE);
            mem_wdata = i_q[B0_LSB +: 8];
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         a_q        <= '0;
         i_q        <= '0;
         word_count <= '0;
         range_err  <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            a_q <= in_addr[ADDR_W-1:0];
            i_q <= in_instr;
         end
         if (accept && !legal)
            range_err <= 1'b1;
         if (state == WR_B0 && word_count != '1)
            word_count <= word_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random words checked
// against a queue-of-pending-writes reference model.
module tb_imem_loader;
   import imem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [23:0] in_addr;
   logic [23:0] in_instr;

   logic        in_ready, mem_we, busy, range_err;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [15:0] word_count;

   logic        s_ready, s_we, s_busy, s_err;
   logic [9:0]  s_addr;
   logic [7:0]  s_wdata;
   logic [1:0]  s_cnt;

   imem_loader u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_instr(in_instr),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy),
      .word_count(word_count), .range_err(range_err)
   );

   imem_loader #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(s_ready),
      .in_addr(in_addr), .in_instr(in_instr),
      .mem_we(s_we), .mem_addr(s_addr),
      .mem_wdata(s_wdata), .busy(s_busy),
      .word_count(s_cnt), .range_err(s_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      bit last;
   } wr_t;

   wr_t q[$];
   int  m_cnt, m_cnt2;
   bit  m_err, m_acc;
   int  n_chk, n_fail;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: a word becomes three queued byte writes,
   // one retired per clock; ready while at most one remains.
   task automatic model_step();
      bit  rdy;
      wr_t w;
      rdy   = q.size() <= 1;
      m_acc = 1'b0;
      if (q.size() > 0) begin
         w = q.pop_front();
         if (w.last) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
      if (in_valid && rdy) begin
         m_acc = 1'b1;
         if (int'(in_addr) + 2 * 3 <= 1023) begin
            for (int k = 0; k < 3; k++)
               q.push_back('{(int'(in_addr) + 3 * k) % 1024,
                             int'((in_instr >> (8 * (2 - k))) & 24'hFF),
                             k == 2});
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic check_outs();
      bit we;
      we = q.size() > 0;
      chk("mem_we", mem_we, we);
      chk("in_ready", in_ready, q.size() <= 1);
      chk("busy", busy, we);
      if (we) begin
         chk("mem_addr", mem_addr, q[0].addr);
         chk("mem_wdata", mem_wdata, q[0].data);
      end
      chk("word_count", word_count, m_cnt);
      chk("range_err", range_err, m_err);
      chk("sat_we", s_we, we);
      if (we) chk("sat_addr", s_addr, q[0].addr);
      chk("sat_count", s_cnt, m_cnt2);
      chk("sat_err", s_err, m_err);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outs();
   endtask

   task automatic push_word(int a, int d);
      in_addr  = 24'(a);
      in_instr = 24'(d);
      in_valid = 1'b1;
      for (int t = 0; t < 8; t++) begin
         cycle();
         if (m_acc) break;
      end
      if (!m_acc) begin
         n_fail++;
         $display("FAIL accept_timeout: addr %0d not taken", a);
      end
   endtask

   task automatic idle(int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      m_cnt    = 0;
      m_cnt2   = 0;
      m_err    = 1'b0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_addr  = '0;
      in_instr = '0;
      @(negedge clk);
      check_outs();
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // single word
      push_word(0, 24'h1E2801);
      idle(5);

      // back-to-back with valid held high
      push_word(9, 24'h102BFF);
      push_word(20, 24'h000000);
      idle(5);
      chk("b2b_count", word_count, 3);

      // range boundary
      push_word(1017, 24'hA5B6C7);
      idle(4);
      push_word(1018, 24'h123456);
      idle(3);
      chk("range_sticky", range_err, 1);

      // backpressure: data changes every cycle until taken
      push_word(100, 24'h111111);
      in_valid = 1'b1;
      for (int t = 0; t < 6; t++) begin
         in_addr  = 24'($urandom_range(0, 1000));
         in_instr = 24'($urandom);
         cycle();
         if (m_acc) break;
      end
      idle(5);

      // reset in the middle of WR_B1
      push_word(50, 24'hABCDEF);
      in_valid = 1'b0;
      cycle();
      #1 reset = 1'b1;
      #1;
      q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
      m_err  = 1'b0;
      check_outs();
      #1 reset = 1'b0;
      idle(4);

      // saturation on the narrow counter
      for (int k = 0; k < 5; k++) begin
         push_word(200 + 9 * k, int'($urandom & 32'hFFFFFF));
         idle(3);
         chk("sat_seq", s_cnt, (k < 3) ? k + 1 : 3);
      end

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         r        = $urandom_range(0, 9);
         in_valid = $urandom_range(0, 2) != 0;
         if (r < 6)
            in_addr = 24'($urandom_range(0, 1023));
         else if (r < 9)
            in_addr = 24'($urandom_range(1010, 1023));
         else
            in_addr = 24'($urandom);
         in_instr = 24'($urandom);
         cycle();
      end
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader on the write side of the byte-wide instruction memory.
- Accepts 24-bit instruction words over a valid/ready handshake and serialises each word into three byte writes.
- The byte layout matches what the fetch side reassembles: MSB at A, middle byte at A+BYTE_STRIDE, LSB at A+2*BYTE_STRIDE.
- Used by boot/testbench infrastructure to fill instruction memory before or between runs.

Parameters:
- MEM_DEPTH, 1024: number of bytes in instruction memory.
- ADDR_W, 10: width of the memory byte address (log2 MEM_DEPTH).
- BYTE_STRIDE, 3: byte distance between consecutive bytes of one instruction.
- CNT_W, 16: width of the accepted-word counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction word and address are presented.
- in_ready  out  1  loader can accept a word this cycle.
- in_addr  in  24  byte address A of the instruction's MSB.
- in_instr  in  24  instruction word; [23:16] MSB, [7:0] LSB.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- busy  out  1  a write sequence is in progress.
- word_count  out  CNT_W  number of words fully written since reset.
- range_err  out  1  sticky; a word was rejected for an out-of-range address.

Behaviour:
- Reset values (async assert, effective immediately):
  - state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, word_count=0, range_err=0.
  - Latched address and instruction registers cleared.
- States and outputs:
  - IDLE: mem_we=0, in_ready=1.
  - WR_B2: mem_we=1, mem_addr=A, mem_wdata=instr[23:16].
  - WR_B1: mem_we=1, mem_addr=A+BYTE_STRIDE, mem_wdata=instr[15:8].
  - WR_B0: mem_we=1, mem_addr=A+2*BYTE_STRIDE, mem_wdata=instr[7:0].
- in_ready = (state==IDLE) or (state==WR_B0). There is no combinational path from in_* to mem_*; mem_* depend only on state and latched registers.
- busy = (state != IDLE).
- Accept: in_valid and in_ready at a rising edge. On accept, latch in_addr and in_instr.
- Range check on accept: legal iff in_addr + 2*BYTE_STRIDE <= MEM_DEPTH-1, computed at 24+ bits with no truncation.
  - Legal: next state WR_B2.
  - Illegal: word dropped, no write, range_err set to 1, count unchanged. Next state is IDLE (from IDLE or from WR_B0).
- Transitions:
  - WR_B2 -> WR_B1 -> WR_B0 unconditionally.
  - WR_B0 -> WR_B2 if a legal word is accepted that cycle.
  - WR_B0 -> IDLE otherwise.
- Latency: first byte write is the cycle after accept; last byte write is 3 cycles after accept.
- Throughput: back-to-back words sustain 1 word / 3 cycles with mem_we held continuously high.
- Latch update on accept in WR_B0: occurs at the same edge that ends the B0 write. The B0 write uses the old word's values for the whole cycle.
- word_count: increments on the edge leaving WR_B0. Saturates at 2^CNT_W-1 (no wrap).
- range_err: cleared only by reset.
- in_valid held while in_ready=0: the word is not accepted. Inputs may change freely and are not sampled.
- Reset mid-sequence: the remaining byte writes are abandoned and mem_we drops asynchronously. Bytes already written stay in memory; the partial word is not counted.
- mem_addr is the low ADDR_W bits of the computed address. The range check guarantees no wrap.

Decomposition:
- Shared package imem_pkg holds:
  - MEM_DEPTH, BYTE_STRIDE, ADDR_W, INSTR_W=24.
  - State enum (IDLE, WR_B2, WR_B1, WR_B0).
  - Byte-lane slice constants.
- The same package is reused by the fetch-side memory so both ends agree on the layout.
- Single module; no sub-module is warranted.

Test Plan:
- Single word, addr 0, instr 0x1E2801, one-cycle valid -> writes (0,0x1E), (3,0x28), (6,0x01) on cycles 1..3 after accept; word_count=1; busy low on cycle 4.
- Back-to-back: 0x102BFF@9 then 0x000000@20, with in_valid continuously high:
  - Second word accepted in the WR_B0 cycle of the first.
  - Six consecutive mem_we cycles: (9,10),(12,2B),(15,FF),(20,00),(23,00),(26,00).
  - word_count=2.
- Range boundary, MEM_DEPTH=1024:
  - addr 1017 -> writes to 1017/1020/1023.
  - addr 1018 -> no mem_we, range_err=1, word_count unchanged, in_ready stays 1.
- Backpressure: in_valid asserted during WR_B2 with new data -> in_ready=0 for WR_B2/WR_B1; accepted in WR_B0; captured data equals the values present at that edge.
- Reset asserted mid-cycle during WR_B1 -> mem_we=0 immediately; state IDLE; word_count=0; range_err=0; no WR_B0 write after reset release.
- Saturation with CNT_W=2: write 5 legal words -> word_count reads 1,2,3,3,3.
